// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU round-robin scheduler:
//   - ALU opcode values (ADD..SADD) and the legal opcode range
//   - scheduler FSM state encoding
//   - op_is_legal(): tells whether an opcode lies in the legal range
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_SADD = 6;
    localparam int OP_MIN  = 1;
    localparam int OP_MAX  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when the opcode selects one of the implemented ALU operations.
    function automatic logic op_is_legal(input int unsigned op);
        return (op >= OP_MIN) && (op <= OP_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at the requester
// after the last winner and wraps modulo NUM_REQ.
// Ports:
//   i_req     - request vector
//   i_last    - index of the previous winner
//   o_grant   - one-hot grant (all zero when no request)
//   o_winner  - index of the granted requester (0 when no request)
//   o_any_req - at least one request is active
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any_req
);

    logic w_found;

    // Walk the requesters starting at i_last+1 and pick the first active one.
    always_comb begin
        int idx;
        o_grant  = '0;
        o_winner = '0;
        w_found  = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(i_last) + k) % NUM_REQ;
            if (!w_found && i_req[ID_W'(idx)]) begin
                w_found                = 1'b1;
                o_grant[ID_W'(idx)]    = 1'b1;
                o_winner               = ID_W'(idx);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Any-request flag, used to open a grant only when someone is asking.
    always_comb begin
        o_any_req = |i_req;
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
// Shares one combinational ALU between NUM_REQ requesters. A round-robin
// arbiter picks a requester; its operands are latched onto the ALU ports, the
// ALU result is registered one cycle later and returned on a tagged response
// channel that honours backpressure.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req_valid / req_ready         - per-requester handshake
//   req_opA / req_opB / req_opcode- packed per-requester operands/opcode
//   alu_opA / alu_opB / alu_opcode- registered operands to the ALU
//   alu_result                    - combinational ALU result
//   resp_valid / resp_ready       - response handshake
//   resp_id / resp_result / resp_err - response payload
//   busy                          - scheduler is not idle
// -----------------------------------------------------------------------------
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int data_width   = 32,
    parameter int opcode_width = 7,
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*data_width-1:0]  req_opA,
    input  logic [NUM_REQ*data_width-1:0]  req_opB,
    input  logic [NUM_REQ*opcode_width-1:0] req_opcode,
    output logic [data_width-1:0]          alu_opA,
    output logic [data_width-1:0]          alu_opB,
    output logic [opcode_width-1:0]        alu_opcode,
    input  logic [data_width-1:0]          alu_result,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [ID_W-1:0]                resp_id,
    output logic [data_width-1:0]          resp_result,
    output logic                           resp_err,
    output logic                           busy
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ID_W-1:0]         r_last;
    logic [ID_W-1:0]         r_id;
    logic [data_width-1:0]   r_alu_opA;
    logic [data_width-1:0]   r_alu_opB;
    logic [opcode_width-1:0] r_alu_opcode;
    logic                    r_resp_valid;
    logic [ID_W-1:0]         r_resp_id;
    logic [data_width-1:0]   r_resp_result;
    logic                    r_resp_err;

    logic [NUM_REQ-1:0]      w_arb_grant;
    logic [ID_W-1:0]         w_arb_winner;
    logic                    w_any_req;
    logic                    w_window;
    logic                    w_grant;
    logic [data_width-1:0]   w_sel_opA;
    logic [data_width-1:0]   w_sel_opB;
    logic [opcode_width-1:0] w_sel_opcode;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req     (req_valid),
        .i_last    (r_last),
        .o_grant   (w_arb_grant),
        .o_winner  (w_arb_winner),
        .o_any_req (w_any_req)
    );

    // Grant window: idle, or a response is being consumed this cycle so a new
    // transaction can start back-to-back.
    always_comb begin
        w_window = (r_state == IDLE) || ((r_state == RESP) && resp_ready);
        w_grant  = w_window && w_any_req;
    end

    // Operand mux selecting the winner's slice of the packed request buses.
    always_comb begin
        w_sel_opA    = '0;
        w_sel_opB    = '0;
        w_sel_opcode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_winner == ID_W'(i)) begin
                w_sel_opA    = req_opA[i*data_width +: data_width];
                w_sel_opB    = req_opB[i*data_width +: data_width];
                w_sel_opcode = req_opcode[i*opcode_width +: opcode_width];
            end else begin
                w_sel_opA    = w_sel_opA;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next_state = EXEC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (w_grant) begin
                        w_next_state = EXEC;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM outputs: ready goes only to the winner while the window is open.
    always_comb begin
        if (w_grant) begin
            req_ready = w_arb_grant;
        end else begin
            req_ready = '0;
        end
        busy = (r_state != IDLE);
    end

    // Datapath: operand latch on grant, result capture in EXEC, response
    // release on handshake. Operands are left untouched after completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last        <= ID_W'(NUM_REQ - 1);
            r_id          <= '0;
            r_alu_opA     <= '0;
            r_alu_opB     <= '0;
            r_alu_opcode  <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_alu_opA    <= w_sel_opA;
                r_alu_opB    <= w_sel_opB;
                r_alu_opcode <= w_sel_opcode;
                r_id         <= w_arb_winner;
                r_last       <= w_arb_winner;
            end
            if (r_state == EXEC) begin
                r_resp_valid  <= 1'b1;
                r_resp_id     <= r_id;
                r_resp_result <= alu_result;
                r_resp_err    <= !op_is_legal(32'(r_alu_opcode));
            end else if ((r_state == RESP) && resp_ready) begin
                r_resp_valid  <= 1'b0;
            end
        end
    end

    assign alu_opA     = r_alu_opA;
    assign alu_opB     = r_alu_opB;
    assign alu_opcode  = r_alu_opcode;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int OW = 7;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_opA;
    logic [NR*DW-1:0]  req_opB;
    logic [NR*OW-1:0]  req_opcode;
    logic [DW-1:0]     alu_opA;
    logic [DW-1:0]     alu_opB;
    logic [OW-1:0]     alu_opcode;
    logic [DW-1:0]     alu_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [IW-1:0]     resp_id;
    logic [DW-1:0]     resp_result;
    logic              resp_err;
    logic              busy;

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    alu_rr_scheduler #(
        .data_width   (DW),
        .opcode_width (OW),
        .NUM_REQ      (NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opA     (req_opA),
        .req_opB     (req_opB),
        .req_opcode  (req_opcode),
        .alu_opA     (alu_opA),
        .alu_opB     (alu_opB),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU attached to the scheduler's ALU ports.
    always_comb begin
        case (int'(alu_opcode))
            OP_ADD:  alu_result = alu_opA + alu_opB;
            OP_SUB:  alu_result = alu_opA - alu_opB;
            OP_AND:  alu_result = alu_opA & alu_opB;
            OP_OR:   alu_result = alu_opA | alu_opB;
            OP_XOR:  alu_result = alu_opA ^ alu_opB;
            OP_SADD: alu_result = DW'($signed(alu_opA) + $signed(alu_opB));
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] op);
        req_opA[idx*DW +: DW]    = a;
        req_opB[idx*DW +: DW]    = b;
        req_opcode[idx*OW +: OW] = op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction with resp_ready held high.
    task automatic single(input string tag, input int idx, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [OW-1:0] op,
                          input logic [DW-1:0] exp_res, input logic exp_err);
        logic [NR-1:0] onehot;
        onehot = 4'b0001 << idx;
        set_req(idx, a, b, op);
        req_valid = onehot;
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(onehot));
        tick();
        req_valid = '0;
        chk({tag, "_exec_busy"}, 64'(busy), 64'd1);
        chk({tag, "_exec_opA"}, 64'(alu_opA), 64'(a));
        chk({tag, "_exec_nvalid"}, 64'(resp_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, "_id"}, 64'(resp_id), 64'(idx));
        chk({tag, "_result"}, 64'(resp_result), 64'(exp_res));
        chk({tag, "_err"}, 64'(resp_err), 64'(exp_err));
        tick();
        chk({tag, "_done_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_done_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [NR-1:0] exp_rdy;
        int w;
        rst        = 1'b1;
        req_valid  = '0;
        req_opA    = '0;
        req_opB    = '0;
        req_opcode = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_opA", 64'(alu_opA), 64'd0);
        chk("rst_result", 64'(resp_result), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        tick();

        // 1: single ADD from requester 0
        single("t1", 0, 32'd5, 32'd3, 7'd1, 32'd8, 1'b0);

        // 2: all four request SUB continuously; pointer restarted at reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 32'(10 + i), 32'd1, 7'd2);
        req_valid = 4'b1111;
        #1;
        chk("t2_first_ready", 64'(req_ready), 64'd1);
        for (int g = 0; g < 5; g++) begin
            w = g % NR;
            tick();
            chk("t2_exec_nvalid", 64'(resp_valid), 64'd0);
            chk("t2_exec_opA", 64'(alu_opA), 64'(10 + w));
            tick();
            chk("t2_valid", 64'(resp_valid), 64'd1);
            chk("t2_id", 64'(resp_id), 64'(w));
            chk("t2_result", 64'(resp_result), 64'(9 + w));
            if (g < 4) begin
                exp_rdy = 4'b0001 << ((g + 1) % NR);
                chk("t2_ready", 64'(req_ready), 64'(exp_rdy));
            end else begin
                req_valid = '0;
                #1;
                chk("t2_last_ready", 64'(req_ready), 64'd0);
            end
        end
        tick();
        chk("t2_idle", 64'(busy), 64'd0);

        // 3: backpressure for 5 cycles, pending request granted on release
        resp_ready = 1'b0;
        set_req(1, 32'd100, 32'd20, 7'd1);
        req_valid = 4'b0010;
        #1;
        chk("t3_ready", 64'(req_ready), 64'b0010);
        tick();
        set_req(2, 32'd7, 32'd2, 7'd3);
        req_valid = 4'b0100;
        chk("t3_exec_ready", 64'(req_ready), 64'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", 64'(resp_valid), 64'd1);
            chk("t3_hold_id", 64'(resp_id), 64'd1);
            chk("t3_hold_result", 64'(resp_result), 64'd120);
            chk("t3_hold_err", 64'(resp_err), 64'd0);
            chk("t3_hold_ready", 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(req_ready), 64'b0100);
        chk("t3_release_valid", 64'(resp_valid), 64'd1);
        tick();
        req_valid = '0;
        chk("t3_b2b_nvalid", 64'(resp_valid), 64'd0);
        chk("t3_b2b_opA", 64'(alu_opA), 64'd7);
        tick();
        chk("t3_b2b_valid", 64'(resp_valid), 64'd1);
        chk("t3_b2b_id", 64'(resp_id), 64'd2);
        chk("t3_b2b_result", 64'(resp_result), 64'd2);
        tick();
        chk("t3_idle", 64'(busy), 64'd0);

        // 4: signed add and illegal opcode
        single("t4_sadd", 3, 32'hFFFF_FFFE, 32'h0000_0001, 7'd6, 32'hFFFF_FFFF, 1'b0);
        single("t4_ill", 0, 32'h1234_5678, 32'h0000_0001, 7'h7F, 32'h0, 1'b1);

        // 5: reset during EXEC discards the transaction
        set_req(2, 32'd50, 32'd5, 7'd1);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        chk("t5_in_exec", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", 64'(resp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_opA", 64'(alu_opA), 64'd0);
        chk("t5_opcode", 64'(alu_opcode), 64'd0);
        chk("t5_id", 64'(resp_id), 64'd0);
        chk("t5_result", 64'(resp_result), 64'd0);
        chk("t5_err", 64'(resp_err), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_no_resp", 64'(resp_valid), 64'd0);
        end
        set_req(0, 32'd40, 32'd2, 7'd1);
        req_valid = 4'b1111;
        #1;
        chk("t5_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0;
        tick();
        chk("t5_after_id", 64'(resp_id), 64'd0);
        chk("t5_after_result", 64'(resp_result), 64'd42);
        tick();

        // 6: add wrap-around
        single("t6", 1, 32'hFFFF_FFFF, 32'h0000_0001, 7'd1, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
